// File: rtl/decoder_pkg.sv
// ---------------------------------------------------------------------------
// decoder_pkg
// Shared definitions for the scanning one-hot decoder.
//   MODE_DECODE / MODE_SCAN : values of the 1-bit mode input
//   MAX_SEL_W / MAX_OUT_W   : widest select the onehot() helper supports
//   onehot(sel)             : returns a vector with only bit 'sel' set
// ---------------------------------------------------------------------------
package decoder_pkg;

  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  // The result is sized for the widest select. Callers size-cast it down to
  // their own 2**SEL_W output width. The upper bits are zero for any select
  // that fits in that width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
    logic [MAX_OUT_W-1:0] vec;
    vec      = '0;
    vec[sel] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/decoder_scan_n_if.sv
// ---------------------------------------------------------------------------
// decoder_scan_n_if
// Control/result bundle of the scanning decoder.
//   master : control logic side (drives en, mode, sel_in, sel_load, period;
//            observes out, idx, wrap)
//   slave  : the decoder itself
// ---------------------------------------------------------------------------
interface decoder_scan_n_if #(
  parameter int SEL_W = 3,
  parameter int DIV_W = 4
);
  localparam int OUT_W = 2 ** SEL_W;

  logic             en;
  logic             mode;
  logic [SEL_W-1:0] sel_in;
  logic             sel_load;
  logic [DIV_W-1:0] period;
  logic [OUT_W-1:0] out;
  logic [SEL_W-1:0] idx;
  logic             wrap;

  modport master (
    output en, mode, sel_in, sel_load, period,
    input  out, idx, wrap
  );

  modport slave (
    input  en, mode, sel_in, sel_load, period,
    output out, idx, wrap
  );

endinterface

// File: rtl/dwell_counter.sv
// ---------------------------------------------------------------------------
// dwell_counter
// Counts how long the scanning decoder has stayed on its current line.
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : force the count back to 0 (takes priority over run)
//   run        : count this cycle; restart from 0 when tick fires
//   period     : last count value of a dwell (dwell = period+1 cycles)
//   tick       : run is high and the dwell has expired this cycle
// ---------------------------------------------------------------------------
module dwell_counter #(
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             run,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Using >= rather than == lets a period reduced mid-dwell end that dwell
  // on the very next edge instead of waiting for the counter to roll over.
  assign tick = run && (cnt_q >= period);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (run) begin
      if (tick) cnt_d = '0;
      else      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_scan_n.sv
// ---------------------------------------------------------------------------
// decoder_scan_n
// Registered SEL_W-to-2**SEL_W one-hot decoder with enable. It also has an
// auto-scan mode that steps the active line every period+1 cycles.
//   clk, rst_n : clock and synchronous active-low reset
//   bus.en     : 0 blanks the output; idx and the dwell count hold
//   bus.mode   : MODE_DECODE follows sel_in loads, MODE_SCAN auto-rotates
//   bus.sel_in / bus.sel_load : index load (a phase set while scanning)
//   bus.period : dwell length minus one
//   bus.out    : registered one-hot (or all-zero) output
//   bus.idx    : registered current index
//   bus.wrap   : one-cycle pulse when a scan step wraps to line 0
// ---------------------------------------------------------------------------
module decoder_scan_n
  import decoder_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int DIV_W = 4
) (
  input logic              clk,
  input logic              rst_n,
  decoder_scan_n_if.slave  bus
);

  localparam int OUT_W = 2 ** SEL_W;

  logic [SEL_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             mode_q;

  logic             mode_changed;
  logic             scanning;
  logic             dwell_clr;
  logic             dwell_run;
  logic             tick;

  assign mode_changed = (bus.mode != mode_q);
  assign scanning     = bus.en && (bus.mode == MODE_SCAN);

  // The dwell restarts on a mode change, in decode, and on a phase set.
  // It only advances while scanning with none of those happening.
  assign dwell_clr = mode_changed || (bus.en && ((bus.mode == MODE_DECODE) || bus.sel_load));
  assign dwell_run = scanning && !mode_changed && !bus.sel_load;

  dwell_counter #(
    .DIV_W (DIV_W)
  ) u_dwell (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (dwell_clr),
    .run    (dwell_run),
    .period (bus.period),
    .tick   (tick)
  );

  // The output is decoded from idx_d, not idx_q, so the registered out and
  // idx always describe the same line. A load wins over a dwell advance.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    out_d  = '0;
    if (bus.en) begin
      if (bus.sel_load) begin
        idx_d = bus.sel_in;
      end else if (scanning && tick) begin
        idx_d  = idx_q + 1'b1;
        wrap_d = &idx_q;
      end
      out_d = OUT_W'(onehot(MAX_SEL_W'(idx_d)));
    end
  end

  // mode_q keeps sampling during reset. This means a mode held steady across
  // reset is not seen as a change on release, so the first dwell after reset
  // is a full one.
  always_ff @(posedge clk) begin
    mode_q <= bus.mode;
    if (!rst_n) begin
      idx_q  <= '0;
      out_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      idx_q  <= idx_d;
      out_q  <= out_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus.out  = out_q;
  assign bus.idx  = idx_q;
  assign bus.wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan_n.sv
// ---------------------------------------------------------------------------
// tb_decoder_scan_n
// Directed, self-checking bench for decoder_scan_n with SEL_W=3 and DIV_W=4.
// ---------------------------------------------------------------------------
module tb_decoder_scan_n;

  localparam int SEL_W = 3;
  localparam int DIV_W = 4;

  logic clk;
  logic rst_n;

  int checkCount;
  int errorCount;

  decoder_scan_n_if #(.SEL_W(SEL_W), .DIV_W(DIV_W)) bus ();

  decoder_scan_n #(
    .SEL_W (SEL_W),
    .DIV_W (DIV_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against the bench's expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Advances n clock edges; inputs change and outputs are sampled 1 ns later
  task automatic applyStimulus(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Checks out, idx and wrap together
  task automatic checkAll(input string tag, input logic [7:0] expOut,
                          input logic [2:0] expIdx, input logic expWrap);
    checkOutput({tag, ".out"},  32'(bus.out),  32'(expOut));
    checkOutput({tag, ".idx"},  32'(bus.idx),  32'(expIdx));
    checkOutput({tag, ".wrap"}, 32'(bus.wrap), 32'(expWrap));
  endtask

  // Independent watchdog so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] expOut;
    checkCount   = 0;
    errorCount   = 0;

    // Reset held for two cycles
    rst_n        = 1'b0;
    bus.en       = 1'b0;
    bus.mode     = 1'b0;
    bus.sel_in   = '0;
    bus.sel_load = 1'b0;
    bus.period   = '0;
    applyStimulus(2);
    checkAll("reset", 8'h00, 3'd0, 1'b0);

    // First decode load after reset
    rst_n        = 1'b1;
    bus.en       = 1'b1;
    bus.sel_in   = 3'd5;
    bus.sel_load = 1'b1;
    applyStimulus(1);
    bus.sel_load = 1'b0;
    checkAll("decode5", 8'b0010_0000, 3'd5, 1'b0);

    // Every select value in turn
    for (int i = 0; i < 8; i++) begin
      bus.sel_in   = 3'(i);
      bus.sel_load = 1'b1;
      applyStimulus(1);
      expOut = 8'd1 << i;
      checkOutput($sformatf("decode_out%0d", i), 32'(bus.out), 32'(expOut));
      checkOutput($sformatf("decode_idx%0d", i), 32'(bus.idx), i);
    end
    bus.sel_load = 1'b0;
    applyStimulus(1);
    checkAll("decode_hold", 8'h80, 3'd7, 1'b0);

    // Enable gating with an ignored load
    bus.sel_in   = 3'd3;
    bus.sel_load = 1'b1;
    applyStimulus(1);
    checkAll("decode3", 8'b0000_1000, 3'd3, 1'b0);
    bus.en       = 1'b0;
    bus.sel_in   = 3'd6;
    applyStimulus(1);
    bus.sel_load = 1'b0;
    checkAll("en_off1", 8'h00, 3'd3, 1'b0);
    applyStimulus(3);
    checkAll("en_off4", 8'h00, 3'd3, 1'b0);
    bus.en = 1'b1;
    applyStimulus(1);
    checkAll("en_on", 8'b0000_1000, 3'd3, 1'b0);

    // Scan with period=2 starting from line 0
    bus.sel_in   = 3'd0;
    bus.sel_load = 1'b1;
    applyStimulus(1);
    bus.sel_load = 1'b0;
    checkAll("scan_start", 8'h01, 3'd0, 1'b0);
    bus.period = 4'd2;
    bus.mode   = 1'b1;
    applyStimulus(1);
    checkAll("scan_modechg", 8'h01, 3'd0, 1'b0);
    for (int j = 1; j <= 24; j++) begin
      applyStimulus(1);
      expOut = 8'd1 << ((j / 3) % 8);
      checkOutput($sformatf("scan_out_c%0d", j), 32'(bus.out), 32'(expOut));
      checkOutput($sformatf("scan_wrap_c%0d", j), 32'(bus.wrap), (j == 24) ? 1 : 0);
    end
    checkOutput("scan_idx_end", 32'(bus.idx), 0);

    // Phase set on the cycle the dwell expires
    applyStimulus(2);
    checkAll("phase_pre", 8'h01, 3'd0, 1'b0);
    bus.sel_in   = 3'd7;
    bus.sel_load = 1'b1;
    applyStimulus(1);
    bus.sel_load = 1'b0;
    checkAll("phase_set", 8'h80, 3'd7, 1'b0);
    applyStimulus(2);
    checkAll("phase_dwell", 8'h80, 3'd7, 1'b0);
    applyStimulus(1);
    checkAll("phase_wrap", 8'h01, 3'd0, 1'b1);

    // period=0 rotates every cycle
    bus.period = 4'd0;
    for (int j = 1; j <= 8; j++) begin
      applyStimulus(1);
      expOut = 8'd1 << (j % 8);
      checkOutput($sformatf("p0_out_c%0d", j), 32'(bus.out), 32'(expOut));
      checkOutput($sformatf("p0_wrap_c%0d", j), 32'(bus.wrap), (j == 8) ? 1 : 0);
    end

    // Period cut from 9 to 1 while cnt=5 advances on the next edge
    bus.period = 4'd9;
    applyStimulus(5);
    checkAll("p9_cnt5", 8'h01, 3'd0, 1'b0);
    bus.period = 4'd1;
    applyStimulus(1);
    checkAll("p_cut", 8'h02, 3'd1, 1'b0);

    // Reset while idx=4 and cnt=1
    bus.sel_in   = 3'd4;
    bus.sel_load = 1'b1;
    applyStimulus(1);
    bus.sel_load = 1'b0;
    applyStimulus(1);
    checkAll("pre_rst", 8'h10, 3'd4, 1'b0);
    rst_n = 1'b0;
    applyStimulus(1);
    checkAll("mid_rst", 8'h00, 3'd0, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1);
    checkAll("post_rst1", 8'h01, 3'd0, 1'b0);
    applyStimulus(1);
    checkAll("post_rst2", 8'h02, 3'd1, 1'b0);

    // Back to decode keeps the current line
    bus.mode = 1'b0;
    applyStimulus(1);
    checkAll("to_decode", 8'h02, 3'd1, 1'b0);
    applyStimulus(2);
    checkAll("decode_stay", 8'h02, 3'd1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
